// File: rtl/code_lock_pkg.sv
// Shared types and constants for the multi-digit code lock.
package code_lock_pkg;

  typedef enum logic [1:0] {ENTRY, OPEN, LOCKOUT} state_t;

  // Index 0 is the glyph for hex digit 0; segments are {dp,g,f,e,d,c,b,a}.
  localparam logic [15:0][7:0] HEX_GLYPH = {
    8'h71, 8'h79, 8'h5e, 8'h39, 8'h7c, 8'h77, 8'h6f, 8'h7f,
    8'h07, 8'h7d, 8'h6d, 8'h66, 8'h4f, 8'h5b, 8'h06, 8'h3f
  };

  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_OPEN = 8'h3f;

  localparam int LED_OPEN  = 0;
  localparam int LED_ERROR = 1;
  localparam int LED_ALARM = 2;

endpackage

// File: rtl/seg7_hex_enc.sv
// Combinational DW-bit digit to seven-segment glyph encoder (dp always off).
module seg7_hex_enc
  import code_lock_pkg::*;
#(
  parameter int DW = 3
) (
  input  logic [DW-1:0] digit,
  output logic [7:0]    seg
);

  logic [3:0] idx;

  assign idx = 4'(digit);
  assign seg = HEX_GLYPH[idx];

endmodule

// File: rtl/code_lock_multi.sv
// N-digit code lock with attempt limit, timed lockout and per-digit 7-seg display.
// Define CODE_PROG_EN to allow reprogramming the password while OPEN.
module code_lock_multi
  import code_lock_pkg::*;
#(
  parameter int                   DIGITS      = 4,
  parameter int                   DW          = 3,
  parameter logic [DIGITS*DW-1:0] PASSWORD    = 12'hB8A,
  parameter int                   MAX_TRIES   = 3,
  parameter int                   LOCKOUT_CYC = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DW-1:0]         digit_in,
  input  logic                  digit_vld,
  input  logic                  comf,
  input  logic                  clr,
  input  logic                  lock_req,
  output logic [2:0]            led,
  output logic [3:0]            tries_left,
  output logic [8*DIGITS-1:0]   seg_out,
  output logic                  busy_lock
);

  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = (LOCKOUT_CYC > 0) ? $clog2(LOCKOUT_CYC + 1) : 1;
  localparam logic [CW-1:0] FULL       = CW'(DIGITS);
  localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYC);

  state_t               state, state_n;
  logic [DIGITS*DW-1:0] entry_buf, buf_n;
  logic [DIGITS*DW-1:0] pwd, pwd_n;
  logic [CW-1:0]        count, count_n;
  logic [3:0]           tries_n;
  logic [2:0]           led_n;
  logic [TW-1:0]        timer, timer_n;
  logic [8*DIGITS-1:0]  disp_n;
  logic [7:0]           glyph [DIGITS];

  // Next-state logic; input priority is comf > clr > digit_vld.
  always_comb begin
    state_n = state;
    buf_n   = entry_buf;
    count_n = count;
    tries_n = tries_left;
    led_n   = led;
    timer_n = timer;
    pwd_n   = pwd;
    case (state)
      ENTRY: begin
        if (comf) begin
          buf_n   = '0;
          count_n = '0;
          if (count == FULL && entry_buf == pwd) begin
            state_n = OPEN;
            led_n   = 3'b001;
            tries_n = TRIES_INIT;
          end else if (tries_left <= 4'd1) begin
            state_n = LOCKOUT;
            led_n   = 3'b110;
            tries_n = 4'd0;
            timer_n = TIMER_LOAD;
          end else begin
            led_n   = 3'b010;
            tries_n = tries_left - 4'd1;
          end
        end else if (clr) begin
          buf_n   = '0;
          count_n = '0;
        end else if (digit_vld && count < FULL) begin
          buf_n[(DIGITS-1-int'(count))*DW +: DW] = digit_in;
          count_n          = count + 1'b1;
          led_n[LED_ERROR] = 1'b0;
        end
      end
      OPEN: begin
        if (lock_req) begin
          state_n = ENTRY;
          led_n   = 3'b000;
          buf_n   = '0;
          count_n = '0;
        end
`ifdef CODE_PROG_EN
        else if (comf) begin
          if (count == FULL) begin
            pwd_n   = entry_buf;
            buf_n   = '0;
            count_n = '0;
          end
        end else if (clr) begin
          buf_n   = '0;
          count_n = '0;
        end else if (digit_vld && count < FULL) begin
          buf_n[(DIGITS-1-int'(count))*DW +: DW] = digit_in;
          count_n = count + 1'b1;
        end
`endif
      end
      LOCKOUT: begin
        // A zero lockout length means only rst can leave this state.
        if (LOCKOUT_CYC != 0) begin
          if (timer <= TW'(1)) begin
            state_n = ENTRY;
            tries_n = TRIES_INIT;
            led_n   = 3'b000;
            timer_n = '0;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
      end
      default: state_n = ENTRY;
    endcase
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_hex_enc #(.DW(DW)) u_enc (
      .digit (buf_n[(DIGITS-1-g)*DW +: DW]),
      .seg   (glyph[g])
    );
  end

  // Display is built from next-state values so it lands with the other outputs.
  always_comb begin
    disp_n = '0;
    for (int p = 0; p < DIGITS; p++) begin
      if (state_n == LOCKOUT)
        disp_n[(DIGITS-1-p)*8 +: 8] = SEG_DASH;
      else if (state_n == OPEN)
`ifdef CODE_PROG_EN
        disp_n[(DIGITS-1-p)*8 +: 8] = (p < int'(count_n)) ? glyph[p] : SEG_OPEN;
`else
        disp_n[(DIGITS-1-p)*8 +: 8] = SEG_OPEN;
`endif
      else
        disp_n[(DIGITS-1-p)*8 +: 8] = (p < int'(count_n)) ? glyph[p] : SEG_DASH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ENTRY;
      entry_buf  <= '0;
      count      <= '0;
      tries_left <= TRIES_INIT;
      led        <= 3'b000;
      busy_lock  <= 1'b0;
      timer      <= '0;
      pwd        <= PASSWORD;
      seg_out    <= {DIGITS{SEG_DASH}};
    end else begin
      state      <= state_n;
      entry_buf  <= buf_n;
      count      <= count_n;
      tries_left <= tries_n;
      led        <= led_n;
      busy_lock  <= (state_n == LOCKOUT);
      timer      <= timer_n;
      pwd        <= pwd_n;
      seg_out    <= disp_n;
    end
  end

endmodule

// File: tb/tb_code_lock_multi.sv
// Directed bench for code_lock_multi: one lock with an 8-cycle lockout and one permanent.
// Covers CODE_PROG_EN reprogramming when that macro is defined.
module tb_code_lock_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  digit_in = '0;
  logic        digit_vld = 1'b0;
  logic        comf = 1'b0;
  logic        clr = 1'b0;
  logic        lock_req = 1'b0;

  logic [2:0]  led, led_p;
  logic [3:0]  tries_left, tries_p;
  logic [31:0] seg_out, seg_p;
  logic        busy_lock, busy_p;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  code_lock_multi #(.LOCKOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_vld(digit_vld),
    .comf(comf), .clr(clr), .lock_req(lock_req),
    .led(led), .tries_left(tries_left), .seg_out(seg_out), .busy_lock(busy_lock)
  );

  code_lock_multi #(.LOCKOUT_CYC(0)) dut_perm (
    .clk(clk), .rst(rst), .digit_in(digit_in), .digit_vld(digit_vld),
    .comf(comf), .clr(clr), .lock_req(lock_req),
    .led(led_p), .tries_left(tries_p), .seg_out(seg_p), .busy_lock(busy_p)
  );

  // Called on a falling edge; holds the pulse across exactly one rising edge.
  task automatic applyStimulus(input logic [2:0] d, input logic v, input logic c,
                               input logic cl, input logic lr);
    digit_in  = d;
    digit_vld = v;
    comf      = c;
    clr       = cl;
    lock_req  = lr;
    @(negedge clk);
    digit_vld = 1'b0;
    comf      = 1'b0;
    clr       = 1'b0;
    lock_req  = 1'b0;
  endtask

  task automatic pressDigit(input logic [2:0] d);
    applyStimulus(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pressComf();
    applyStimulus(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic pressClr();
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic pressLock();
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic enterCode(input logic [2:0] a, input logic [2:0] b,
                           input logic [2:0] c, input logic [2:0] d);
    pressDigit(a);
    pressDigit(b);
    pressDigit(c);
    pressDigit(d);
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("reset_led", led, 3'b000);
    checkOutput("reset_tries", tries_left, 4'd3);
    checkOutput("reset_seg", seg_out, 32'h40404040);
    checkOutput("reset_busy", busy_lock, 1'b0);

    pressDigit(3'd5);
    checkOutput("first_digit_seg", seg_out, 32'h6d404040);
    pressDigit(3'd6);
    pressDigit(3'd1);
    pressDigit(3'd2);
    checkOutput("full_entry_seg", seg_out, 32'h6d7d065b);
    pressComf();
    checkOutput("open_led", led, 3'b001);
    checkOutput("open_tries", tries_left, 4'd3);
    checkOutput("open_seg", seg_out, 32'h3f3f3f3f);
`ifndef CODE_PROG_EN
    pressDigit(3'd3);
    checkOutput("open_digit_ignored", seg_out, 32'h3f3f3f3f);
    pressComf();
    checkOutput("open_comf_ignored", led, 3'b001);
`endif
    pressLock();
    checkOutput("relock_led", led, 3'b000);
    checkOutput("relock_seg", seg_out, 32'h40404040);

    enterCode(3'd5, 3'd6, 3'd1, 3'd3);
    pressComf();
    checkOutput("wrong_led", led, 3'b010);
    checkOutput("wrong_tries", tries_left, 4'd2);
    checkOutput("wrong_seg", seg_out, 32'h40404040);
    pressClr();
    checkOutput("clr_keeps_error", led, 3'b010);
    pressDigit(3'd5);
    checkOutput("digit_clears_error", led, 3'b000);
    checkOutput("digit_after_wrong_seg", seg_out, 32'h6d404040);
    pressClr();
    checkOutput("clr_seg", seg_out, 32'h40404040);
    checkOutput("clr_tries", tries_left, 4'd2);

    applyStimulus(3'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("prio_tries", tries_left, 4'd1);
    checkOutput("prio_seg", seg_out, 32'h40404040);
    checkOutput("prio_led", led, 3'b010);
    enterCode(3'd1, 3'd2, 3'd3, 3'd4);
    pressDigit(3'd5);
    checkOutput("fifth_digit_ignored", seg_out, 32'h065b4f66);
    pressClr();
    checkOutput("clr_mid_seg", seg_out, 32'h40404040);
    checkOutput("clr_mid_tries", tries_left, 4'd1);

    pulseReset();
    checkOutput("rst_tries", tries_left, 4'd3);
    enterCode(3'd1, 3'd1, 3'd1, 3'd1);
    pressComf();
    checkOutput("bad1_tries", tries_left, 4'd2);
    pressDigit(3'd5);
    pressDigit(3'd6);
    pressComf();
    checkOutput("bad2_tries", tries_left, 4'd1);
    pressComf();
    checkOutput("lock_led", led, 3'b110);
    checkOutput("lock_busy", busy_lock, 1'b1);
    checkOutput("lock_tries", tries_left, 4'd0);
    checkOutput("lock_seg", seg_out, 32'h40404040);
    pressDigit(3'd5);
    checkOutput("lock_digit_ignored", seg_out, 32'h40404040);
    pressComf();
    checkOutput("lock_comf_tries", tries_left, 4'd0);
    idle(5);
    checkOutput("lock_last_cycle", busy_lock, 1'b1);
    idle(1);
    checkOutput("unlock_busy", busy_lock, 1'b0);
    checkOutput("unlock_tries", tries_left, 4'd3);
    checkOutput("unlock_led", led, 3'b000);

    idle(1000);
    checkOutput("perm_busy", busy_p, 1'b1);
    checkOutput("perm_led", led_p, 3'b110);
    checkOutput("perm_tries", tries_p, 4'd0);
    pulseReset();
    checkOutput("perm_rst_busy", busy_p, 1'b0);
    checkOutput("perm_rst_tries", tries_p, 4'd3);
    checkOutput("perm_rst_led", led_p, 3'b000);
    checkOutput("perm_rst_seg", seg_p, 32'h40404040);

`ifdef CODE_PROG_EN
    enterCode(3'd5, 3'd6, 3'd1, 3'd2);
    pressComf();
    checkOutput("prog_open", led, 3'b001);
    enterCode(3'd7, 3'd7, 3'd0, 3'd1);
    checkOutput("prog_entry_seg", seg_out, 32'h07073f06);
    pressComf();
    checkOutput("prog_stays_open", led, 3'b001);
    pressLock();
    enterCode(3'd5, 3'd6, 3'd1, 3'd2);
    pressComf();
    checkOutput("prog_old_fails", tries_left, 4'd2);
    enterCode(3'd7, 3'd7, 3'd0, 3'd1);
    pressComf();
    checkOutput("prog_new_opens", led, 3'b001);
    pulseReset();
    enterCode(3'd5, 3'd6, 3'd1, 3'd2);
    pressComf();
    checkOutput("prog_rst_restores", led, 3'b001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/code_lock_multi.md
Name: code_lock_multi

Overview:
- Parametrised successor to the team's two-digit code box: N-digit password entered one digit at a time, configurable attempt limit, timed lockout and per-digit seven-segment display.
- Sits behind the shared debounce block; all input pulses arrive already debounced and one cycle wide.
- Drives status LEDs and the display bus directly.

Parameters:
- DIGITS, 4, number of password digits (1..8).
- DW, 3, bits per digit (1..4; digit value 0..2^DW-1).
- PASSWORD, 12'hB8A, reset password (digits 5,6,1,2); first-entered digit in bits [DIGITS*DW-1 -: DW].
- MAX_TRIES, 3, wrong attempts allowed before lockout (1..15).
- LOCKOUT_CYC, 50_000_000, lockout duration in clk cycles; 0 = permanent until rst.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digit_in  in  DW  digit value, sampled when digit_vld=1
- digit_vld  in  1  one-cycle pulse: append digit_in
- comf  in  1  one-cycle pulse: confirm entry
- clr  in  1  one-cycle pulse: discard current entry
- lock_req  in  1  one-cycle pulse: relock from OPEN
- led  out  3  {alarm, error, open}, active-high
- tries_left  out  4  remaining attempts
- seg_out  out  8*DIGITS  7-seg codes; bits [8*DIGITS-1 -: 8] = first digit (leftmost); bit7 (dp) always 0
- busy_lock  out  1  1 while in LOCKOUT

Behaviour:
- Reset: state=ENTRY, buffer cleared, count=0, tries_left=MAX_TRIES, led=3'b000, busy_lock=0, lockout timer=0, every seg_out byte=8'h40 ('-'), password register=PASSWORD.
- All outputs are registered; response appears the cycle after the input pulse.
- Input priority within one cycle: comf > clr > digit_vld; lower-priority pulses in the same cycle are dropped.
- ENTRY, digit_vld with count<DIGITS: store digit at position count, count++, led.error<=0.
- ENTRY, digit_vld with count==DIGITS: ignored, no state change.
- ENTRY, clr: buffer and count cleared; no attempt consumed; led.error unchanged.
- ENTRY, comf, count==DIGITS and buffer==password: go to OPEN; led=3'b001; tries_left<=MAX_TRIES; buffer cleared.
- ENTRY, comf otherwise (mismatch or incomplete entry, including count=0): attempt consumed; buffer cleared; tries_left--.
  - If tries_left becomes 0: go to LOCKOUT; led=3'b110; busy_lock=1; timer<=LOCKOUT_CYC.
  - Else: stay in ENTRY with led=3'b010.
- OPEN: digit_vld, clr and comf ignored (except under CODE_PROG_EN). lock_req -> ENTRY, led=000, buffer cleared.
- LOCKOUT: all inputs ignored.
  - LOCKOUT_CYC>0: timer decrements every cycle; on the cycle the timer reads 1 -> ENTRY next cycle, tries_left=MAX_TRIES, led=000, busy_lock=0. Lockout lasts exactly LOCKOUT_CYC cycles.
  - LOCKOUT_CYC=0: stay in LOCKOUT until rst.
- Display:
  - ENTRY: entered positions show the hex glyph of their digit; unentered positions show 8'h40.
  - OPEN: all positions 8'h3f.
  - LOCKOUT: all positions 8'h40.
- Timer width is $clog2(LOCKOUT_CYC+1), minimum 1. tries_left never wraps below 0.
- rst asserted in any state, mid-entry or mid-lockout, returns to reset values the next cycle; a programmed password reverts to PASSWORD.

Optional Feature:
- Macro CODE_PROG_EN.
- Defined: in OPEN, digit_vld and clr fill and clear the buffer exactly as in ENTRY (display shows it). comf with count==DIGITS writes the buffer into the password register, clears the buffer and stays in OPEN. comf with count<DIGITS is ignored.
- Undefined: password is the constant PASSWORD; digit, clr and comf inputs are ignored in OPEN.

Decomposition:
- Package code_lock_pkg holds:
  - state enum {ENTRY, OPEN, LOCKOUT};
  - 16-entry 8-bit hex glyph table (0=3f,1=06,2=5b,3=4f,4=66,5=6d,6=7d,7=07,8=7f,9=6f,A=77,b=7c,C=39,d=5e,E=79,F=71);
  - SEG_DASH=8'h40;
  - LED field index constants.
- One sub-module, seg7_hex_enc: combinational DW-bit to 8-bit glyph encoder, instantiated per digit via generate.

Test Plan:
- Defaults, LOCKOUT_CYC=8: digits 5,6,1,2 then comf -> led=001, tries_left=3, seg_out=32'h3f3f3f3f; lock_req -> led=000, seg_out=32'h40404040.
- Enter 5,6,1,3 then comf -> led=010, tries_left=2; next digit 5 -> led=000, seg_out=32'h6d404040.
- Three wrong comf (one with only 2 digits) -> third gives led=110, busy_lock=1; digit/comf pulses during lockout have no effect; exactly 8 cycles later state=ENTRY, tries_left=3.
- Same cycle digit_vld=1 (digit 4) and comf=1 with an empty buffer -> attempt consumed (tries_left=2), digit not stored; 5th digit_vld after 4 digits is ignored; clr mid-entry clears without changing tries_left.
- LOCKOUT_CYC=0: exhaust tries -> lockout persists for 1000 cycles; rst=1 for one cycle -> ENTRY, tries_left=3, led=000.
- With CODE_PROG_EN: open, enter 7,7,0,1, comf -> relock; 5,6,1,2 fails (tries_left=2); 7,7,0,1 opens; rst restores 5,6,1,2.
